pipeline_hold_ctrl: RTL and testbench

PIPELINE_HOLD_CTRL -- requirements
Module: pipeline_hold_ctrl

---
 rtl/pipeline_hold_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hold_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hold_ctrl.sv
// IF/ID hold and flush controller: resolves Redirect > Stall > advance, drives the
// PC write enable and ID/EX bubble, and keeps stall/flush statistics.
module pipeline_hold_ctrl #(
    parameter int          MAX_STALL = 3,
    parameter logic [31:0] NOP_INST  = 32'h00000013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_inst,
    output logic        PC_WrEn,
    output logic        ID_EX_Bubble,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic        stall_timeout,
    output logic [1:0]  state
);

    localparam int RW = (MAX_STALL + 2 > 2) ? $clog2(MAX_STALL + 2) : 1;
    localparam logic [RW-1:0] RUN_SAT   = RW'(MAX_STALL + 1);
    localparam logic [RW-1:0] RUN_LIMIT = RW'(MAX_STALL);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          eff_stall_s;
    logic [31:0]   if_id_pc_r;
    logic [31:0]   if_id_inst_r;
    logic          if_id_valid_r;
    logic [31:0]   stall_cnt_r;
    logic [31:0]   flush_cnt_r;
    logic          stall_timeout_r;
    logic [RW-1:0] run_cnt_r;

    // A Stall coinciding with a Redirect targets a wrong-path instruction and is dropped.
    assign eff_stall_s = Stall & ~Redirect;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: identical priority from every state.
    always_comb begin
        state_nxt_s = RUN;
        case (state_r)
            RUN, HOLD, FLUSH: begin
                if (Redirect) begin
                    state_nxt_s = FLUSH;
                end else if (Stall) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // Zero-latency pipeline controls; reset keeps the PC frozen and ID/EX empty.
    always_comb begin
        PC_WrEn      = 1'b0;
        ID_EX_Bubble = 1'b1;
        if (!rstn) begin
            PC_WrEn      = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (Redirect) begin
            PC_WrEn      = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (Stall) begin
            PC_WrEn      = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else begin
            PC_WrEn      = 1'b1;
            ID_EX_Bubble = 1'b0;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            if_id_pc_r    <= 32'h0000_0000;
            if_id_inst_r  <= NOP_INST;
            if_id_valid_r <= 1'b0;
        end else if (Redirect) begin
            if_id_pc_r    <= IF_PC;
            if_id_inst_r  <= NOP_INST;
            if_id_valid_r <= 1'b0;
        end else if (Stall) begin
            if_id_pc_r    <= if_id_pc_r;
            if_id_inst_r  <= if_id_inst_r;
            if_id_valid_r <= if_id_valid_r;
        end else begin
            if_id_pc_r    <= IF_PC;
            if_id_inst_r  <= IF_inst;
            if_id_valid_r <= 1'b1;
        end
    end

    // Statistics counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_r <= 32'h0000_0000;
            flush_cnt_r <= 32'h0000_0000;
        end else begin
            stall_cnt_r <= eff_stall_s ? stall_cnt_r + 32'd1 : stall_cnt_r;
            flush_cnt_r <= Redirect    ? flush_cnt_r + 32'd1 : flush_cnt_r;
        end
    end

    // Consecutive-stall run counter and sticky timeout on the (MAX_STALL+1)th stall.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            run_cnt_r       <= '0;
            stall_timeout_r <= 1'b0;
        end else if (eff_stall_s) begin
            run_cnt_r       <= (run_cnt_r >= RUN_SAT) ? RUN_SAT : run_cnt_r + RW'(1);
            stall_timeout_r <= stall_timeout_r | (run_cnt_r >= RUN_LIMIT);
        end else begin
            run_cnt_r       <= '0;
            stall_timeout_r <= stall_timeout_r;
        end
    end

    assign IF_ID_PC      = if_id_pc_r;
    assign IF_ID_inst    = if_id_inst_r;
    assign IF_ID_valid   = if_id_valid_r;
    assign stall_cnt     = stall_cnt_r;
    assign flush_cnt     = flush_cnt_r;
    assign stall_timeout = stall_timeout_r;
    assign state         = state_r;

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Directed bench for pipeline_hold_ctrl with hand-computed expectations.
module tb_pipeline_hold_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        Stall;
    logic        Redirect;
    logic [31:0] IF_PC;
    logic [31:0] IF_inst;
    logic        PC_WrEn;
    logic        ID_EX_Bubble;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        stall_timeout;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    pipeline_hold_ctrl #(.MAX_STALL(3), .NOP_INST(32'h00000013)) dut (
        .clk(clk), .rstn(rstn), .Stall(Stall), .Redirect(Redirect),
        .IF_PC(IF_PC), .IF_inst(IF_inst), .PC_WrEn(PC_WrEn),
        .ID_EX_Bubble(ID_EX_Bubble), .IF_ID_PC(IF_ID_PC), .IF_ID_inst(IF_ID_inst),
        .IF_ID_valid(IF_ID_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .stall_timeout(stall_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},      IF_ID_PC,      32'h0);
        chk({tag, "_inst"},    IF_ID_inst,    32'h00000013);
        chk({tag, "_valid"},   {31'd0, IF_ID_valid},   32'd0);
        chk({tag, "_scnt"},    stall_cnt,     32'd0);
        chk({tag, "_fcnt"},    flush_cnt,     32'd0);
        chk({tag, "_tmo"},     {31'd0, stall_timeout}, 32'd0);
        chk({tag, "_state"},   {30'd0, state},         32'd0);
    endtask

    initial begin
        rstn = 1'b0; Stall = 1'b0; Redirect = 1'b0; IF_PC = 32'h0; IF_inst = 32'h0;
        #1;
        chk("rst_wren",   {31'd0, PC_WrEn},      32'd0);
        chk("rst_bubble", {31'd0, ID_EX_Bubble}, 32'd1);
        Redirect = 1'b1;
        #1;
        chk("rst_wren_redir", {31'd0, PC_WrEn}, 32'd0);
        cycle();
        cycle();
        Redirect = 1'b0;
        chk_reset_vals("reset");

        // Free-flowing fetch: IF/ID follows one cycle later.
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IF_PC   = 32'(i * 4);
            IF_inst = 32'hA000_0000 + 32'(i);
            #1;
            chk("run_wren",   {31'd0, PC_WrEn},      32'd1);
            chk("run_bubble", {31'd0, ID_EX_Bubble}, 32'd0);
            cycle();
            chk("run_pc",    IF_ID_PC,   32'(i * 4));
            chk("run_inst",  IF_ID_inst, 32'hA000_0000 + 32'(i));
            chk("run_valid", {31'd0, IF_ID_valid}, 32'd1);
        end
        chk("run_scnt", stall_cnt, 32'd0);
        chk("run_fcnt", flush_cnt, 32'd0);

        // Load-use hold with 0x10 in ID.
        IF_PC = 32'h10; IF_inst = 32'hB000_0010;
        cycle();
        chk("lu_pre_pc", IF_ID_PC, 32'h10);
        IF_PC = 32'h14; IF_inst = 32'hB000_0014; Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lu_wren",   {31'd0, PC_WrEn},      32'd0);
            chk("lu_bubble", {31'd0, ID_EX_Bubble}, 32'd1);
            cycle();
            chk("lu_pc",    IF_ID_PC,   32'h10);
            chk("lu_inst",  IF_ID_inst, 32'hB000_0010);
            chk("lu_state", {30'd0, state}, 32'd1);
        end
        Stall = 1'b0;
        chk("lu_scnt", stall_cnt, 32'd2);
        chk("lu_tmo",  {31'd0, stall_timeout}, 32'd0);
        cycle();
        chk("lu_post_pc",    IF_ID_PC, 32'h14);
        chk("lu_post_state", {30'd0, state}, 32'd0);

        // Redirect wins over a simultaneous Stall.
        IF_PC = 32'h40; IF_inst = 32'hC000_0040; Redirect = 1'b1; Stall = 1'b1;
        #1;
        chk("rd_wren",   {31'd0, PC_WrEn},      32'd1);
        chk("rd_bubble", {31'd0, ID_EX_Bubble}, 32'd1);
        cycle();
        chk("rd_inst",  IF_ID_inst, 32'h00000013);
        chk("rd_pc",    IF_ID_PC,   32'h40);
        chk("rd_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rd_state", {30'd0, state}, 32'd2);
        chk("rd_fcnt",  flush_cnt, 32'd1);
        chk("rd_scnt",  stall_cnt, 32'd2);

        // Stale stall against the flushed bubble still holds.
        Redirect = 1'b0; IF_PC = 32'h44; IF_inst = 32'hC000_0044;
        #1;
        chk("fs_wren", {31'd0, PC_WrEn}, 32'd0);
        cycle();
        chk("fs_pc",    IF_ID_PC, 32'h40);
        chk("fs_valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("fs_state", {30'd0, state}, 32'd1);
        chk("fs_scnt",  stall_cnt, 32'd3);
        Stall = 1'b0;
        cycle();
        chk("fs_post_valid", {31'd0, IF_ID_valid}, 32'd1);
        chk("fs_post_state", {30'd0, state}, 32'd0);

        // Four consecutive stalls exceed MAX_STALL=3.
        Stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("to_tmo", {31'd0, stall_timeout}, (i == 4) ? 32'd1 : 32'd0);
        end
        #1;
        chk("to_wren_obeyed", {31'd0, PC_WrEn}, 32'd0);
        chk("to_scnt", stall_cnt, 32'd7);
        Stall = 1'b0;
        cycle();
        cycle();
        chk("to_sticky", {31'd0, stall_timeout}, 32'd1);
        chk("to_scnt_post", stall_cnt, 32'd7);

        // Reset in the middle of a hold run.
        Stall = 1'b1;
        cycle();
        chk("mr_state", {30'd0, state}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("mr_wren", {31'd0, PC_WrEn}, 32'd0);
        cycle();
        chk_reset_vals("mid_reset");
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("mr_tmo",  {31'd0, stall_timeout}, 32'd0);
        chk("mr_scnt", stall_cnt, 32'd3);
        Stall = 1'b0;
        cycle();

        // stall_cnt wraps modulo 2^32.
        force dut.stall_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_r;
        Stall = 1'b1;
        cycle();
        chk("wrap_scnt", stall_cnt, 32'd0);
        Stall = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
